lcd_text_driver: RTL and testbench
==================================

Name: lcd_text_driver

Overview:
- Downstream display stage for mips_top. Consumes a 32-character (2x16) text buffer of CPU debug state and drives the board's HD44780-compatible character LCD in 4-bit write-only mode (LCDE/LCDRS/LCDRW/LCDDAT).
- Runs the power-up init sequence once, then refreshes both lines continuously.
- The text buffer is sampled at the start of each frame.

Parameters:
T_POWERUP, 750000, cycles idle after reset before first init nibble (15 ms @ 50 MHz)
T_INIT1, 205000, wait after first 0x3 init nibble (4.1 ms)
T_INIT2, 5000, wait after second 0x3 init nibble (100 us)
T_SETUP, 2, cycles RS/DAT stable before LCDE rises
T_E_HIGH, 12, cycles LCDE held high
T_NIBBLE_GAP, 50, cycles between upper and lower nibble of one byte
T_CMD, 2000, wait after each byte and after 3rd/4th init nibble (40 us)
T_CLEAR, 82000, wait after clear-display command (1.64 ms)

Ports:
CCLK  input  1  system clock
rst  input  1  asynchronous reset, active-high
text  input  256  char i (0..31) at text[255-8*i -: 8]; chars 0-15 line 1, 16-31 line 2
LCDE  output  1  LCD enable strobe
LCDRS  output  1  0 = command, 1 = data
LCDRW  output  1  tied 0 (write only)
LCDDAT  output  4  nibble bus
init_done  output  1  high once configuration is complete; stays high until reset
frame_done  output  1  one-cycle pulse after the 32nd char of a frame completes its T_CMD wait

Behaviour:
- Reset, asynchronous, applies at any time including mid-strobe. Outputs: LCDE=0, LCDRS=0, LCDRW=0, LCDDAT=0, init_done=0, frame_done=0. FSM returns to PWR_WAIT and all counters clear.
- Nibble write, used for every transfer:
  - Drive LCDRS/LCDDAT.
  - Hold for T_SETUP cycles.
  - LCDE=1 for T_E_HIGH cycles.
  - LCDE=0; RS/DAT held 1 more cycle.
  - Then wait the post-delay given by the caller.
- Byte write: upper nibble with post-delay T_NIBBLE_GAP, then lower nibble with post-delay T_CMD (T_CLEAR for 0x01).
- FSM states:
  - PWR_WAIT: count T_POWERUP, then INIT.
  - INIT: nibbles 0x3 (wait T_INIT1), 0x3 (T_INIT2), 0x3 (T_CMD), 0x2 (T_CMD); all with RS=0.
  - CFG: bytes 0x28, 0x06, 0x0C, 0x01 (RS=0). Set init_done when the 0x01 wait ends.
  - FRAME_START: latch text into an internal 256-bit shadow register, clear char index. Takes 1 cycle.
  - SET_ADDR: byte 0x80 (index 0) or 0xC0 (index 16), RS=0.
  - WRITE_CHAR: byte shadow[index], RS=1. Increment index.
    - Index 16 goes to SET_ADDR.
    - Index 32 pulses frame_done, then goes to FRAME_START.
    - Otherwise stays in WRITE_CHAR.
- Changes to text mid-frame are not visible until the next FRAME_START; no tearing within a frame.
- Wait counters are 20 bits, load N-1, terminate at 0. A delay parameter of 1 gives exactly 1 cycle.
- LCDE never rises while LCDRS/LCDDAT are changing. DAT/RS change only when LCDE=0 and at least 1 cycle after its fall.
- LCDRW is constant 0 in all states.

Decomposition:
- Package lcd_pkg:
  - command constants LCD_FUNC_4BIT=8'h28, LCD_ENTRY_INC=8'h06, LCD_DISP_ON=8'h0C, LCD_CLEAR=8'h01, LCD_LINE1=8'h80, LCD_LINE2=8'hC0;
  - FSM state encoding.
- Sub-module lcd_nibble_writer:
  - inputs: start, rs, nibble, post_delay[19:0];
  - outputs: LCDE, LCDRS, LCDDAT, done (1-cycle pulse);
  - ignores start while busy.
- The top FSM sequences nibbles and bytes through it.

Test Plan:
- All delay parameters overridden small (T_POWERUP=20, T_INIT1=10, T_INIT2=5, T_SETUP=2, T_E_HIGH=3, T_NIBBLE_GAP=4, T_CMD=6, T_CLEAR=8).
- Reset then idle: no LCDE edge for 20 cycles. First strobes carry LCDDAT 3,3,3,2 with LCDRS=0. Then nibble pairs 2/8, 0/6, 0/C, 0/1. init_done rises after the last clear wait.
- text = "MIPS PIPELINE   " / "PC=00000000     ": bus monitor decodes 0x80, 'M','I',... 16 chars with RS=1, then 0xC0, then 'P','C','=',... One frame_done pulse after char 31.
- Strobe timing checker on every strobe: LCDE high exactly 3 cycles; RS/DAT stable ≥2 cycles before rise and ≥1 after fall; LCDRW always 0.
- Change text when char 5 is being written: rest of the frame shows the old text; the next frame (after frame_done) shows the new text.
- Assert rst while LCDE=1 mid-frame: LCDE drops to 0 asynchronously; init_done=0; full power-up/init sequence repeats before any data write.
- Back-to-back frames: frame_done pulses are spaced exactly by one full frame period (constant cycle count); address commands alternate 0x80/0xC0 every 16 chars.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared command bytes, FSM encodings and helpers for the HD44780 text driver.
package lcd_pkg;

    localparam logic [7:0] LCD_FUNC_4BIT = 8'h28;
    localparam logic [7:0] LCD_ENTRY_INC = 8'h06;
    localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
    localparam logic [7:0] LCD_CLEAR     = 8'h01;
    localparam logic [7:0] LCD_LINE1     = 8'h80;
    localparam logic [7:0] LCD_LINE2     = 8'hC0;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        CFG,
        FRAME_START,
        SET_ADDR,
        WRITE_CHAR
    } lcd_state_t;

    typedef enum logic [2:0] {
        NW_IDLE,
        NW_SETUP,
        NW_EHIGH,
        NW_HOLD,
        NW_POST
    } nw_state_t;

    // Configuration bytes, issued in order after the 4-bit wake-up nibbles.
    function automatic logic [7:0] cfg_cmd(input logic [1:0] step);
        case (step)
            2'd0:    cfg_cmd = LCD_FUNC_4BIT;
            2'd1:    cfg_cmd = LCD_ENTRY_INC;
            2'd2:    cfg_cmd = LCD_DISP_ON;
            default: cfg_cmd = LCD_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_text_driver_if.sv
// Character LCD pin bundle (4-bit write-only HD44780 bus).
interface lcd_text_driver_if;
    logic       LCDE;
    logic       LCDRS;
    logic       LCDRW;
    logic [3:0] LCDDAT;

    modport master (output LCDE, LCDRS, LCDRW, LCDDAT);
    modport slave  (input  LCDE, LCDRS, LCDRW, LCDDAT);
endinterface

// File: rtl/lcd_nibble_writer.sv
// One LCD nibble strobe: setup, enable pulse, hold, then caller-chosen post-delay.
// done pulses one cycle when the post-delay expires; start is ignored while busy.
module lcd_nibble_writer import lcd_pkg::*; #(
    parameter int T_SETUP  = 2,
    parameter int T_E_HIGH = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rs,
    input  logic [3:0]  nibble,
    input  logic [19:0] post_delay,
    output logic        LCDE,
    output logic        LCDRS,
    output logic [3:0]  LCDDAT,
    output logic        done
);

    localparam logic [19:0] SETUP_LD = 20'(T_SETUP - 1);
    localparam logic [19:0] EHIGH_LD = 20'(T_E_HIGH - 1);

    nw_state_t   state_q, state_d;
    logic [19:0] cnt_q, post_q;
    logic        cnt_zero;

    assign cnt_zero = (cnt_q == 20'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= NW_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            NW_IDLE:  if (start)    state_d = NW_SETUP;
            NW_SETUP: if (cnt_zero) state_d = NW_EHIGH;
            NW_EHIGH: if (cnt_zero) state_d = NW_HOLD;
            NW_HOLD:                state_d = NW_POST;
            NW_POST:  if (cnt_zero) state_d = NW_IDLE;
            default:                state_d = NW_IDLE;
        endcase
    end

    // Enable is registered from the next state so the pin never glitches on state decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) LCDE <= 1'b0;
        else     LCDE <= (state_d == NW_EHIGH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= 20'd0;
            post_q <= 20'd0;
            LCDRS  <= 1'b0;
            LCDDAT <= 4'd0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                NW_IDLE: if (start) begin
                    LCDRS  <= rs;
                    LCDDAT <= nibble;
                    post_q <= post_delay;
                    cnt_q  <= SETUP_LD;
                end
                NW_SETUP: cnt_q <= cnt_zero ? EHIGH_LD : cnt_q - 20'd1;
                NW_EHIGH: if (!cnt_zero) cnt_q <= cnt_q - 20'd1;
                NW_HOLD:  cnt_q <= post_q - 20'd1;
                NW_POST: begin
                    if (cnt_zero) done  <= 1'b1;
                    else          cnt_q <= cnt_q - 20'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/lcd_text_driver.sv
// Powers up a 2x16 HD44780 in 4-bit mode, then refreshes both lines from a per-frame
// snapshot of text forever; frame_done pulses once per completed 32-char frame.
module lcd_text_driver import lcd_pkg::*; #(
    parameter int T_POWERUP    = 750000,
    parameter int T_INIT1      = 205000,
    parameter int T_INIT2      = 5000,
    parameter int T_SETUP      = 2,
    parameter int T_E_HIGH     = 12,
    parameter int T_NIBBLE_GAP = 50,
    parameter int T_CMD        = 2000,
    parameter int T_CLEAR      = 82000
) (
    input  logic                     CCLK,
    input  logic                     rst,
    input  logic [255:0]             text,
    lcd_text_driver_if.master        lcd,
    output logic                     init_done,
    output logic                     frame_done
);

    lcd_state_t   state_q, state_d;
    logic [19:0]  pwr_cnt_q;
    logic [1:0]   step_q;
    logic         lo_q, pend_q;
    logic [4:0]   idx_q;
    logic [255:0] shadow_q;

    logic         wr_start, wr_rs, wr_done, byte_done;
    logic [3:0]   wr_nib;
    logic [19:0]  wr_post;
    logic [7:0]   cur_byte;
    logic [4:0]   char_sel;
    logic         e_w, rs_w;
    logic [3:0]   dat_w;

    assign byte_done = wr_done && lo_q;
    assign char_sel  = 5'd31 - idx_q;

    always_ff @(posedge CCLK or posedge rst) begin
        if (rst) state_q <= PWR_WAIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PWR_WAIT:    if (pwr_cnt_q == 20'd0)            state_d = INIT;
            INIT:        if (wr_done && step_q == 2'd3)     state_d = CFG;
            CFG:         if (byte_done && step_q == 2'd3)   state_d = FRAME_START;
            FRAME_START:                                    state_d = SET_ADDR;
            SET_ADDR:    if (byte_done)                     state_d = WRITE_CHAR;
            WRITE_CHAR: if (byte_done) begin
                if (idx_q == 5'd15)      state_d = SET_ADDR;
                else if (idx_q == 5'd31) state_d = FRAME_START;
            end
            default:                                        state_d = PWR_WAIT;
        endcase
    end

    always_comb begin
        cur_byte = LCD_LINE1;
        wr_rs    = 1'b0;
        case (state_q)
            CFG:        cur_byte = cfg_cmd(step_q);
            SET_ADDR:   cur_byte = (idx_q == 5'd0) ? LCD_LINE1 : LCD_LINE2;
            WRITE_CHAR: begin
                cur_byte = shadow_q[{char_sel, 3'b000} +: 8];
                wr_rs    = 1'b1;
            end
            default: ;
        endcase

        wr_nib = lo_q ? cur_byte[3:0] : cur_byte[7:4];
        if (!lo_q)                               wr_post = 20'(T_NIBBLE_GAP);
        else if (!wr_rs && cur_byte == LCD_CLEAR) wr_post = 20'(T_CLEAR);
        else                                      wr_post = 20'(T_CMD);

        // Wake-up nibbles are single transfers with their own settle times.
        if (state_q == INIT) begin
            wr_nib = (step_q == 2'd3) ? 4'h2 : 4'h3;
            case (step_q)
                2'd0:    wr_post = 20'(T_INIT1);
                2'd1:    wr_post = 20'(T_INIT2);
                default: wr_post = 20'(T_CMD);
            endcase
        end

        wr_start = !pend_q && (state_q == INIT || state_q == CFG ||
                               state_q == SET_ADDR || state_q == WRITE_CHAR);
    end

    always_ff @(posedge CCLK or posedge rst) begin
        if (rst) begin
            pwr_cnt_q  <= 20'(T_POWERUP - 1);
            step_q     <= 2'd0;
            lo_q       <= 1'b0;
            pend_q     <= 1'b0;
            idx_q      <= 5'd0;
            shadow_q   <= '0;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state_q == PWR_WAIT && pwr_cnt_q != 20'd0)
                pwr_cnt_q <= pwr_cnt_q - 20'd1;
            if (wr_start)
                pend_q <= 1'b1;
            if (wr_done) begin
                pend_q <= 1'b0;
                if (state_q == INIT) begin
                    step_q <= step_q + 2'd1;
                end else begin
                    lo_q <= !lo_q;
                    if (lo_q) begin
                        case (state_q)
                            CFG: begin
                                step_q <= step_q + 2'd1;
                                if (step_q == 2'd3) init_done <= 1'b1;
                            end
                            WRITE_CHAR: begin
                                idx_q <= idx_q + 5'd1;
                                if (idx_q == 5'd31) frame_done <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            if (state_q == FRAME_START) begin
                shadow_q <= text;
                idx_q    <= 5'd0;
            end
        end
    end

    lcd_nibble_writer #(
        .T_SETUP  (T_SETUP),
        .T_E_HIGH (T_E_HIGH)
    ) u_writer (
        .clk        (CCLK),
        .rst        (rst),
        .start      (wr_start),
        .rs         (wr_rs),
        .nibble     (wr_nib),
        .post_delay (wr_post),
        .LCDE       (e_w),
        .LCDRS      (rs_w),
        .LCDDAT     (dat_w),
        .done       (wr_done)
    );

    assign lcd.LCDE   = e_w;
    assign lcd.LCDRS  = rs_w;
    assign lcd.LCDDAT = dat_w;
    assign lcd.LCDRW  = 1'b0;

endmodule

// File: tb/tb_lcd_text_driver.sv
// Bench for lcd_text_driver: nibble scoreboard fed by the stimulus, bus/strobe monitor.
module tb_lcd_text_driver;

    localparam int T_POWERUP = 20, T_INIT1 = 10, T_INIT2 = 5, T_SETUP = 2;
    localparam int T_E_HIGH = 3, T_NIBBLE_GAP = 4, T_CMD = 6, T_CLEAR = 8;
    localparam int FRAME_STROBES = 68;
    localparam int MIN_PERIOD = 34 * (2 * (T_SETUP + T_E_HIGH + 1) + T_NIBBLE_GAP + T_CMD);
    localparam logic [255:0] TEXT_A = {"MIPS PIPELINE   ", "PC=00000000     "};
    localparam logic [255:0] TEXT_B = {"NEW TEXT LINE 1 ", "PC=DEADBEEF     "};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] text;
    logic         init_done, frame_done;

    lcd_text_driver_if lcd();

    lcd_text_driver #(
        .T_POWERUP(T_POWERUP), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_SETUP(T_SETUP),
        .T_E_HIGH(T_E_HIGH), .T_NIBBLE_GAP(T_NIBBLE_GAP), .T_CMD(T_CMD), .T_CLEAR(T_CLEAR)
    ) dut (
        .CCLK       (clk),
        .rst        (rst),
        .text       (text),
        .lcd        (lcd),
        .init_done  (init_done),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [4:0] sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic push_byte(input logic rs, input logic [7:0] b);
        sb.push_back({rs, b[7:4]});
        sb.push_back({rs, b[3:0]});
    endtask

    task automatic push_init();
        sb.push_back(5'h03); sb.push_back(5'h03); sb.push_back(5'h03); sb.push_back(5'h02);
        push_byte(1'b0, 8'h28); push_byte(1'b0, 8'h06);
        push_byte(1'b0, 8'h0C); push_byte(1'b0, 8'h01);
    endtask

    task automatic push_frame(input logic [255:0] t);
        for (int i = 0; i < 32; i++) begin
            if (i == 0)  push_byte(1'b0, 8'h80);
            if (i == 16) push_byte(1'b0, 8'hC0);
            push_byte(1'b1, t[255 - 8*i -: 8]);
        end
    endtask

    // Bus monitor: every sample on the falling clock edge.
    int cyc = 0, e_cnt = 0, stable = 0, since_fall = 1000, strobe_cnt = 0;
    int fd_base = 12, fd_cnt = 0, last_rise_cyc = 0;
    int fd_time[0:15];
    logic e_prev = 1'b0, fd_prev = 1'b0;
    logic [4:0] bus_prev = '0, bus_now, exp_nib;

    always @(negedge clk) begin
        cyc++;
        bus_now = {lcd.LCDRS, lcd.LCDDAT};
        if (rst) begin
            e_prev = 1'b0; fd_prev = 1'b0; e_cnt = 0; stable = 0;
            since_fall = 1000; strobe_cnt = 0; fd_base = 12;
        end else begin
            if (bus_now != bus_prev) begin
                check("bus_hold", (!lcd.LCDE && since_fall >= 1), 1);
                stable = 0;
            end else begin
                stable++;
            end
            if (lcd.LCDE && !e_prev) begin
                check("setup", stable >= T_SETUP, 1);
                check("rw_low", lcd.LCDRW, 0);
                strobe_cnt++;
                last_rise_cyc = cyc;
                if (sb.size() == 0) begin
                    check("sb_underflow", bus_now, 5'h1F);
                end else begin
                    exp_nib = sb.pop_front();
                    check("strobe", bus_now, exp_nib);
                end
                e_cnt = 1;
            end else if (lcd.LCDE) begin
                e_cnt++;
            end
            if (!lcd.LCDE && e_prev) check("e_high", e_cnt, T_E_HIGH);
            if (lcd.LCDE)            since_fall = 0;
            else if (since_fall < 1000) since_fall++;
            if (frame_done) begin
                check("fd_width", fd_prev, 0);
                check("frame_strobes", strobe_cnt - fd_base, FRAME_STROBES);
                fd_base = strobe_cnt;
                fd_cnt++;
                if (fd_cnt < 16) fd_time[fd_cnt] = cyc;
            end
            e_prev  = lcd.LCDE;
            fd_prev = frame_done;
        end
        bus_prev = bus_now;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic quiet_check();
        logic quiet = 1'b1;
        repeat (T_POWERUP) begin
            tick();
            if (lcd.LCDE) quiet = 1'b0;
        end
        check("pwr_quiet", quiet, 1);
    endtask

    task automatic wait_init();
        for (int i = 0; i < 2000 && !init_done; i++) tick();
        check("init_done_rise", init_done, 1);
        check("init_nibbles", strobe_cnt, 12);
        check("clear_wait", (cyc - last_rise_cyc) >= (T_E_HIGH + 1 + T_CLEAR), 1);
    endtask

    task automatic wait_fd(input int n);
        for (int i = 0; i < 3000 && fd_cnt < n; i++) tick();
        check("frame_done_seen", fd_cnt >= n, 1);
    endtask

    task automatic check_rst_outputs(input string tag);
        check({tag, "_lcde"}, lcd.LCDE, 0);
        check({tag, "_rs"}, lcd.LCDRS, 0);
        check({tag, "_rw"}, lcd.LCDRW, 0);
        check({tag, "_dat"}, lcd.LCDDAT, 0);
        check({tag, "_init_done"}, init_done, 0);
        check({tag, "_frame_done"}, frame_done, 0);
    endtask

    initial begin
        int fd_n;
        text = TEXT_A;
        rst  = 1'b1;
        repeat (3) tick();
        check_rst_outputs("reset");
        push_init();
        push_frame(TEXT_A);
        push_frame(TEXT_A);
        rst = 1'b0;
        quiet_check();
        wait_init();
        wait_fd(1);

        // Char 5 of frame 2 starts at global strobe 12 + 68 + 13.
        for (int i = 0; i < 2000 && strobe_cnt < 93; i++) tick();
        check("char5_reached", strobe_cnt >= 93, 1);
        text = TEXT_B;
        push_frame(TEXT_B);
        wait_fd(2);
        push_frame(TEXT_B);
        wait_fd(3);
        push_frame(TEXT_B);
        wait_fd(4);
        check("period_23", fd_time[3] - fd_time[2], fd_time[2] - fd_time[1]);
        check("period_34", fd_time[4] - fd_time[3], fd_time[3] - fd_time[2]);
        check("period_min", (fd_time[2] - fd_time[1]) >= MIN_PERIOD, 1);

        for (int i = 0; i < 1000 && !(lcd.LCDE && strobe_cnt >= fd_base + 20); i++) tick();
        check("mid_strobe", lcd.LCDE, 1);
        #1 rst = 1'b1;
        #1;
        check_rst_outputs("async_rst");
        sb.delete();
        push_init();
        push_frame(TEXT_B);
        repeat (3) tick();
        rst = 1'b0;
        quiet_check();
        wait_init();
        fd_n = fd_cnt;
        wait_fd(fd_n + 1);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
